icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the instruction fetcher and the memory controller.
- Hits return the instruction word one cycle after the request, without touching the memory bus.
- Misses issue a word fetch to the memory controller, wait for the assembled 32-bit word, fill the line and forward the word to the fetcher.
- Outstanding misses are aborted on pipeline clear (misprediction flush).

Parameters:
INDEX_BITS, 4, number of index bits; cache holds 2^INDEX_BITS one-word lines
TAG_BITS, 30-INDEX_BITS, derived; tag width = pc[31:INDEX_BITS+2]

Ports:
clk_in  input  1  system clock, all state updates on rising edge
rst_in  input  1  reset: synchronous, active-high
rdy_in  input  1  global ready; when low, all state holds
clear_in  input  1  pipeline flush; aborts pending miss
fetch_valid_in  input  1  fetcher requests instruction at fetch_pc_in
fetch_pc_in  input  32  request address, word-aligned (bits 1:0 = 00)
inst_ready_out  output  1  one-cycle pulse: inst_out valid for last accepted request
inst_out  output  32  instruction word
mem_need_inst_out  output  1  request word fetch from memory controller
mem_pc_out  output  32  miss address to memory controller
mem_inst_ready_in  input  1  memory controller word-fetch complete (one-cycle pulse)
mem_inst_in  input  32  fetched word, valid while mem_inst_ready_in high

Behaviour:
- Storage: valid[2^INDEX_BITS], tag[], data[]. index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2].
- Priority per edge: rst_in > clear_in > (rdy_in low: hold) > normal operation.
  - clear_in acts regardless of rdy_in, matching the memory controller's abort.
- Reset:
  - All valid bits cleared; state = IDLE.
  - inst_ready_out = 0, inst_out = 0, mem_pc_out = 0.
  - mem_need_inst_out = 0.
- States: IDLE, MISS.
- IDLE, fetch_valid_in high:
  - Hit (valid && tag match): next cycle inst_ready_out = 1, inst_out = data[index]; state stays IDLE.
  - Miss: latch mem_pc_out = fetch_pc_in; state -> MISS; inst_ready_out = 0 next cycle.
- IDLE, fetch_valid_in low: inst_ready_out = 0 next cycle.
- Requests accepted every IDLE cycle, including the cycle inst_ready_out is high. Hit throughput is 1 per cycle.
- MISS:
  - fetch_valid_in and fetch_pc_in are ignored; the fetcher holds its request until inst_ready_out.
  - mem_need_inst_out = (state==MISS) && !mem_inst_ready_in && !clear_in. This is combinational, so the controller never sees a stale request in its completion cycle and does not start a second fetch.
  - On mem_inst_ready_in: write data[index] = mem_inst_in, tag, valid = 1 (index/tag from mem_pc_out). Next cycle inst_ready_out = 1, inst_out = mem_inst_in. state -> IDLE.
  - Controller may delay the fetch arbitrarily (LSB has priority); the cache waits indefinitely with no timeout.
- clear_in high:
  - state -> IDLE; inst_ready_out = 0 next cycle; any pending miss is dropped; no fill occurs.
  - A clear coinciding with mem_inst_ready_in discards the word: no write, no ready.
  - A fetch_valid_in in the same cycle is not accepted.
  - Valid bits are NOT cleared; cache contents survive flushes.
- rdy_in low (no clear/reset): all registers hold, including inst_ready_out. mem_need_inst_out follows its equation from held state.
- A line written by a fill is a hit for the same pc in the very next accepted request.
- Index aliasing: a fill overwrites the previous line with the same index unconditionally.
- No write/invalidate port; self-modifying code is unsupported.

Test Plan:
- Cold miss:
  - Stimulus: reset, then fetch_valid_in=1, pc=0x00000010; memory returns 0x00A00093 after 5 cycles.
  - Required: mem_need_inst_out high with mem_pc_out=0x10 until the ready pulse; inst_ready_out pulses once with 0x00A00093; mem_need_inst_out low in the pulse cycle.
- Hit after fill:
  - Stimulus: re-request pc=0x10.
  - Required: inst_ready_out=1 next cycle, inst_out=0x00A00093; mem_need_inst_out stays 0.
- Back-to-back hits:
  - Stimulus: pcs 0x10 and 0x14 (both filled) on consecutive cycles.
  - Required: two consecutive ready pulses with the correct words; no memory activity.
- Conflict:
  - Stimulus (INDEX_BITS=4): fill 0x10, then fetch 0x50 (same index).
  - Required: 0x50 misses and fills; subsequent fetch of 0x10 misses again.
- Clear during miss:
  - Stimulus: miss on 0x20; assert clear_in in the same cycle as mem_inst_ready_in.
  - Required: no inst_ready_out pulse; next fetch of 0x20 misses; previously filled 0x10 still hits.
- rdy_in stall and reset:
  - Stimulus: drop rdy_in for 3 cycles during MISS.
  - Required: state, mem_pc_out and outputs held.
  - Stimulus: assert rst_in mid-miss.
  - Required: all outputs 0 and 0x10 now misses.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one-word lines.
// Hits answer one cycle after the request. Misses fetch a single word from the
// memory controller, fill the line, and forward the word to the fetcher.
module icache_direct #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        fetch_valid_in,
    input  logic [31:0] fetch_pc_in,
    output logic        inst_ready_out,
    output logic [31:0] inst_out,
    output logic        mem_need_inst_out,
    output logic [31:0] mem_pc_out,
    input  logic        mem_inst_ready_in,
    input  logic [31:0] mem_inst_in
);

    localparam int DATA_W = 32;
    localparam int LINES  = 1 << INDEX_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic                  line_valid [LINES];
    logic [TAG_BITS-1:0]   line_tag   [LINES];
    logic [DATA_W-1:0]     line_data  [LINES];

    logic [INDEX_BITS-1:0] fetch_idx;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  fetch_hit;

    logic                  ready_nxt;
    logic [DATA_W-1:0]     inst_nxt;
    logic [31:0]           mem_pc_nxt;
    logic                  fill_en;

    // Byte-offset bits are always zero for word-aligned fetches.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc_in[1:0], mem_pc_out[1:0]};

    // Address split: the fill uses the latched miss address, not the live pc.
    always_comb begin
        fetch_idx = fetch_pc_in[INDEX_BITS+1:2];
        fetch_tag = fetch_pc_in[31:INDEX_BITS+2];
        fill_idx  = mem_pc_out[INDEX_BITS+1:2];
        fill_tag  = mem_pc_out[31:INDEX_BITS+2];
        fetch_hit = line_valid[fetch_idx] && (line_tag[fetch_idx] == fetch_tag);
    end

    // Combinational so the controller drops the request in its completion
    // cycle and never launches a second fetch for the same miss.
    assign mem_need_inst_out = (state == MISS) && !mem_inst_ready_in && !clear_in;

    // Next-state and next-output logic; clear beats the rdy_in stall.
    always_comb begin
        state_nxt  = state;
        ready_nxt  = inst_ready_out;
        inst_nxt   = inst_out;
        mem_pc_nxt = mem_pc_out;
        fill_en    = 1'b0;

        if (clear_in) begin
            state_nxt = IDLE;
            ready_nxt = 1'b0;
        end else if (rdy_in) begin
            unique case (state)
                IDLE: begin
                    ready_nxt = 1'b0;
                    if (fetch_valid_in) begin
                        if (fetch_hit) begin
                            ready_nxt = 1'b1;
                            inst_nxt  = line_data[fetch_idx];
                        end else begin
                            mem_pc_nxt = fetch_pc_in;
                            state_nxt  = MISS;
                        end
                    end
                end
                MISS: begin
                    ready_nxt = 1'b0;
                    if (mem_inst_ready_in) begin
                        fill_en   = 1'b1;
                        ready_nxt = 1'b1;
                        inst_nxt  = mem_inst_in;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b0;
                end
            endcase
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            inst_ready_out <= 1'b0;
            inst_out       <= '0;
            mem_pc_out     <= '0;
        end else begin
            state          <= state_nxt;
            inst_ready_out <= ready_nxt;
            inst_out       <= inst_nxt;
            mem_pc_out     <= mem_pc_nxt;
        end
    end

    // Valid bits: cleared only by reset, survive pipeline flushes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < LINES; i++) begin
                line_valid[i] <= 1'b0;
            end
        end else if (fill_en) begin
            line_valid[fill_idx] <= 1'b1;
        end
    end

    // Tag and data storage; a fill overwrites whatever shared the index.
    always_ff @(posedge clk_in) begin
        if (fill_en && !rst_in) begin
            line_tag[fill_idx]  <= fill_tag;
            line_data[fill_idx] <= mem_inst_in;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed scoreboard bench for icache_direct.
module tb_icache_direct;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        fetch_valid_in;
    logic [31:0] fetch_pc_in;
    logic        inst_ready_out;
    logic [31:0] inst_out;
    logic        mem_need_inst_out;
    logic [31:0] mem_pc_out;
    logic        mem_inst_ready_in;
    logic [31:0] mem_inst_in;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] W_A = 32'h00A0_0093;
    localparam logic [31:0] W_B = 32'h0010_0113;
    localparam logic [31:0] W_C = 32'hDEAD_BEEF;
    localparam logic [31:0] W_D = 32'h1234_5678;
    localparam logic [31:0] W_E = 32'hCAFE_F00D;

    icache_direct #(.INDEX_BITS(4)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .clear_in          (clear_in),
        .fetch_valid_in    (fetch_valid_in),
        .fetch_pc_in       (fetch_pc_in),
        .inst_ready_out    (inst_ready_out),
        .inst_out          (inst_out),
        .mem_need_inst_out (mem_need_inst_out),
        .mem_pc_out        (mem_pc_out),
        .mem_inst_ready_in (mem_inst_ready_in),
        .mem_inst_in       (mem_inst_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Monitor: every ready pulse must match the oldest expected word.
    always @(negedge clk_in) begin
        if (inst_ready_out === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready: got inst 0x%08h expected no pulse", inst_out);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (inst_out !== e) begin
                    n_fail++;
                    $display("FAIL inst_word: got 0x%08h expected 0x%08h", inst_out, e);
                end
            end
        end
    end

    // Issue a request that must miss; the bench plays memory controller.
    task automatic do_miss(input logic [31:0] pc, input logic [31:0] word, input int delay);
        fetch_valid_in = 1'b1;
        fetch_pc_in    = pc;
        tick();
        for (int i = 0; i < delay; i++) begin
            @(negedge clk_in);
            check("miss_need", {31'b0, mem_need_inst_out}, 32'd1);
            check("miss_pc", mem_pc_out, pc);
            tick();
        end
        mem_inst_ready_in = 1'b1;
        mem_inst_in       = word;
        exp_q.push_back(word);
        @(negedge clk_in);
        check("need_drop_on_ready", {31'b0, mem_need_inst_out}, 32'd0);
        tick();
        mem_inst_ready_in = 1'b0;
        mem_inst_in       = '0;
        fetch_valid_in    = 1'b0;
    endtask

    // Issue a request that must hit without memory traffic.
    task automatic do_hit(input logic [31:0] pc, input logic [31:0] word);
        fetch_valid_in = 1'b1;
        fetch_pc_in    = pc;
        exp_q.push_back(word);
        tick();
        fetch_valid_in = 1'b0;
        @(negedge clk_in);
        check("hit_ready", {31'b0, inst_ready_out}, 32'd1);
        check("hit_no_mem", {31'b0, mem_need_inst_out}, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
        fetch_valid_in = 1'b0; fetch_pc_in = '0;
        mem_inst_ready_in = 1'b0; mem_inst_in = '0;
        tick(); tick();
        rst_in = 1'b0;
        @(negedge clk_in);
        check("rst_ready", {31'b0, inst_ready_out}, 32'd0);
        check("rst_inst", inst_out, 32'd0);
        check("rst_mem_pc", mem_pc_out, 32'd0);
        check("rst_need", {31'b0, mem_need_inst_out}, 32'd0);
        tick();

        // Cold miss, then hit after fill.
        do_miss(32'h10, W_A, 5);
        do_hit(32'h10, W_A);

        // Fill 0x14, then back-to-back hits.
        do_miss(32'h14, W_B, 2);
        fetch_valid_in = 1'b1;
        fetch_pc_in    = 32'h10;
        exp_q.push_back(W_A);
        tick();
        fetch_pc_in    = 32'h14;
        exp_q.push_back(W_B);
        @(negedge clk_in);
        check("b2b_first_ready", {31'b0, inst_ready_out}, 32'd1);
        tick();
        fetch_valid_in = 1'b0;
        @(negedge clk_in);
        check("b2b_second_ready", {31'b0, inst_ready_out}, 32'd1);
        check("b2b_no_mem", {31'b0, mem_need_inst_out}, 32'd0);
        tick();

        // Index conflict: 0x50 evicts 0x10.
        do_miss(32'h50, W_C, 1);
        do_hit(32'h50, W_C);
        do_miss(32'h10, W_A, 1);

        // Clear coinciding with the fill word discards it.
        fetch_valid_in = 1'b1;
        fetch_pc_in    = 32'h20;
        tick();
        fetch_valid_in = 1'b0;
        tick();
        mem_inst_ready_in = 1'b1;
        mem_inst_in       = W_D;
        clear_in          = 1'b1;
        @(negedge clk_in);
        check("clear_need", {31'b0, mem_need_inst_out}, 32'd0);
        tick();
        mem_inst_ready_in = 1'b0;
        clear_in          = 1'b0;
        @(negedge clk_in);
        check("clear_no_ready", {31'b0, inst_ready_out}, 32'd0);
        check("clear_idle_need", {31'b0, mem_need_inst_out}, 32'd0);
        tick();
        do_miss(32'h20, W_D, 1);
        do_hit(32'h10, W_A);

        // rdy_in stall during a miss.
        fetch_valid_in = 1'b1;
        fetch_pc_in    = 32'h30;
        tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("stall_need", {31'b0, mem_need_inst_out}, 32'd1);
            check("stall_pc", mem_pc_out, 32'h30);
            check("stall_ready", {31'b0, inst_ready_out}, 32'd0);
            tick();
        end
        rdy_in = 1'b1;
        mem_inst_ready_in = 1'b1;
        mem_inst_in       = W_E;
        exp_q.push_back(W_E);
        tick();
        mem_inst_ready_in = 1'b0;
        fetch_valid_in    = 1'b0;
        tick();
        do_hit(32'h30, W_E);

        // Reset in the middle of a miss.
        fetch_valid_in = 1'b1;
        fetch_pc_in    = 32'h40;
        tick();
        rst_in = 1'b1;
        fetch_valid_in = 1'b0;
        tick();
        rst_in = 1'b0;
        @(negedge clk_in);
        check("midrst_ready", {31'b0, inst_ready_out}, 32'd0);
        check("midrst_inst", inst_out, 32'd0);
        check("midrst_mem_pc", mem_pc_out, 32'd0);
        check("midrst_need", {31'b0, mem_need_inst_out}, 32'd0);
        tick();
        do_miss(32'h10, W_A, 1);
        tick(); tick();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
